// File: rtl/mio_bus_arbiter.sv
// Two-master round-robin arbiter that sequences one fixed-latency transaction
// at a time onto the shared memory/IO bus and returns a one-cycle ack.
module mio_bus_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic [31:0] bus_addr,
    output logic        bus_mem_w,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        owner,
    output logic        busy
);

    localparam logic [3:0] LAT_C = 4'(LAT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        last, last_nxt;
    logic        owner_q, owner_nxt;
    logic        we_q, we_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [31:0] rdata0_q, rdata0_nxt;
    logic [31:0] rdata1_q, rdata1_nxt;
    logic        grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            last     <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last     <= last_nxt;
            owner_q  <= owner_nxt;
            we_q     <= we_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            rdata0_q <= rdata0_nxt;
            rdata1_q <= rdata1_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        last_nxt   = last;
        owner_nxt  = owner_q;
        we_nxt     = we_q;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        rdata0_nxt = rdata0_q;
        rdata1_nxt = rdata1_q;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the master that was not served last wins.
                    grant     = (m0_req && m1_req) ? ~last : m1_req;
                    owner_nxt = grant;
                    we_nxt    = grant ? m1_we    : m0_we;
                    addr_nxt  = grant ? m1_addr  : m0_addr;
                    wdata_nxt = grant ? m1_wdata : m0_wdata;
                    cnt_nxt   = LAT_C;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    if (!we_q) begin
                        if (owner_q) rdata1_nxt = bus_rdata;
                        else         rdata0_nxt = bus_rdata;
                    end
                    state_nxt = DONE;
                end
            end
            DONE: begin
                last_nxt  = owner_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs decode only flops, so no req reaches the bus combinationally.
    // The write strobe is limited to the first ACCESS cycle (cnt still at LAT).
    assign bus_addr  = (state == ACCESS) ? addr_q  : 32'd0;
    assign bus_wdata = (state == ACCESS) ? wdata_q : 32'd0;
    assign bus_mem_w = (state == ACCESS) && (cnt == LAT_C) && we_q;
    assign m0_ack    = (state == DONE) && !owner_q;
    assign m1_ack    = (state == DONE) && owner_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign owner     = owner_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: reset, single reads/writes, contention,
// reset abort, and a LAT=0 / LAT=15 latency sweep on two extra instances.
module tb_mio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;
    logic        m0_ack, m1_ack, bus_mem_w, owner, busy;
    logic [31:0] cur_addr, cur_rd;

    logic        z0_req, z15_req;
    logic [31:0] z0_m0_rdata, z0_m1_rdata, z0_bus_addr, z0_bus_wdata;
    logic        z0_m0_ack, z0_m1_ack, z0_bus_mem_w, z0_owner, z0_busy;
    logic [31:0] z15_m0_rdata, z15_m1_rdata, z15_bus_addr, z15_bus_wdata;
    logic        z15_m0_ack, z15_m1_ack, z15_bus_mem_w, z15_owner, z15_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Decoder model: returns the programmed word only while the expected address is on the bus.
    assign bus_rdata = (bus_addr == cur_addr) ? cur_rd : 32'h0BADF00D;

    mio_bus_arbiter #(.LAT(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .bus_addr(bus_addr), .bus_mem_w(bus_mem_w), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .owner(owner), .busy(busy)
    );

    mio_bus_arbiter #(.LAT(0)) dut_lat0 (
        .clk(clk), .rst(rst),
        .m0_req(z0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(z0_m0_rdata), .m0_ack(z0_m0_ack),
        .m1_req(1'b0), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(z0_m1_rdata), .m1_ack(z0_m1_ack),
        .bus_addr(z0_bus_addr), .bus_mem_w(z0_bus_mem_w), .bus_wdata(z0_bus_wdata),
        .bus_rdata(32'd0), .owner(z0_owner), .busy(z0_busy)
    );

    mio_bus_arbiter #(.LAT(15)) dut_lat15 (
        .clk(clk), .rst(rst),
        .m0_req(z15_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(z15_m0_rdata), .m0_ack(z15_m0_ack),
        .m1_req(1'b0), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(z15_m1_rdata), .m1_ack(z15_m1_ack),
        .bus_addr(z15_bus_addr), .bus_mem_w(z15_bus_mem_w), .bus_wdata(z15_bus_wdata),
        .bus_rdata(32'd0), .owner(z15_owner), .busy(z15_busy)
    );

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int cyc, strobes, addr_cyc, wrong_ack, wd_bad;
        bit got;
        @(negedge clk);
        cur_addr = v.addr;
        cur_rd   = v.rd;
        drive(v.m, 1'b1, v.we, v.addr, v.wdata);
        cyc = 0; got = 0; strobes = 0; addr_cyc = 0; wrong_ack = 0; wd_bad = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_mem_w) begin
                strobes++;
                if (bus_wdata !== v.wdata || bus_addr !== v.addr) wd_bad++;
            end
            if (bus_addr === v.addr) addr_cyc++;
            if (v.m ? m0_ack : m1_ack) wrong_ack++;
            if (v.m ? m1_ack : m0_ack) got = 1;
        end
        drive(v.m, 1'b0, v.we, v.addr, v.wdata);
        check($sformatf("v%0d_latency", idx), got ? cyc : -1, 32'd3);
        check($sformatf("v%0d_strobes", idx), strobes, v.we ? 32'd1 : 32'd0);
        check($sformatf("v%0d_strobe_data", idx), wd_bad, 32'd0);
        check($sformatf("v%0d_addr_cycles", idx), addr_cyc, 32'd2);
        check($sformatf("v%0d_other_ack", idx), wrong_ack, 32'd0);
        check($sformatf("v%0d_owner", idx), 32'(owner), 32'(v.m));
        check($sformatf("v%0d_rdata", idx), v.m ? m1_rdata : m0_rdata, v.exp_rdata);
        @(negedge clk);
        check($sformatf("v%0d_ack_one_cycle", idx), 32'(m0_ack | m1_ack), 32'd0);
        check($sformatf("v%0d_rdata_held", idx), v.m ? m1_rdata : m0_rdata, v.exp_rdata);
    endtask

    initial begin
        int cyc, n_ack, both, m0_acks, strobes;
        int lat0, lat15, st0, st15;
        logic order[4];
        int ack_cyc[4];

        vecs[0] = '{m: 1'b0, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0,
                    rd: 32'hDEAD_BEEF, exp_rdata: 32'hDEAD_BEEF};
        vecs[1] = '{m: 1'b1, we: 1'b1, addr: 32'hF000_0004, wdata: 32'h1234_5678,
                    rd: 32'h5555_5555, exp_rdata: 32'h0};
        vecs[2] = '{m: 1'b1, we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0,
                    rd: 32'hA5A5_0001, exp_rdata: 32'hA5A5_0001};
        vecs[3] = '{m: 1'b0, we: 1'b1, addr: 32'h0000_0030, wdata: 32'h0000_1111,
                    rd: 32'h7777_7777, exp_rdata: 32'hDEAD_BEEF};
        vecs[4] = '{m: 1'b1, we: 1'b1, addr: 32'h0000_0044, wdata: 32'hCAFE_0044,
                    rd: 32'h6666_6666, exp_rdata: 32'hA5A5_0001};

        // Reset held with both masters requesting.
        rst = 1'b0;
        z0_req = 1'b0; z15_req = 1'b0;
        cur_addr = 32'hFFFF_FFF0; cur_rd = 32'h0;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_bus_mem_w", 32'(bus_mem_w), 32'd0);
        check("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("first_tie_owner", 32'(owner), 32'd0);
        check("first_tie_busy", 32'(busy), 32'd1);
        check("first_tie_addr", bus_addr, 32'h0000_0004);
        cyc = 0;
        while (!m0_ack && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("first_tie_ack", 32'(m0_ack), 32'd1);
        check("first_tie_no_m1_ack", 32'(m1_ack), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

        // Contention: last grant was m1, so the order must be m0, m1, m0, m1.
        @(negedge clk);
        cur_addr = 32'h0000_0060; cur_rd = 32'h0000_6060;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0064, 32'h0);
        cyc = 0; n_ack = 0; both = 0;
        while (n_ack < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m0_ack && m1_ack) both++;
            if (m0_ack || m1_ack) begin
                order[n_ack]   = m1_ack;
                ack_cyc[n_ack] = cyc;
                n_ack++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("cont_ack_count", n_ack, 32'd4);
        check("cont_both_acks", both, 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k < n_ack) begin
                check($sformatf("cont_order%0d", k), 32'(order[k]), 32'(k % 2));
                check($sformatf("cont_ack_cycle%0d", k), ack_cyc[k], 32'(3 + 4 * k));
            end
        end
        @(negedge clk);

        // Abort an m0 read in its second ACCESS cycle while m1 waits.
        @(negedge clk);
        cur_addr = 32'h0000_0070; cur_rd = 32'h7070_7070;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0070, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0050, 32'h0000_0077);
        @(negedge clk);
        check("abort_owner_m0", 32'(owner), 32'd0);
        check("abort_addr_m0", bus_addr, 32'h0000_0070);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_bus_addr", bus_addr, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_m0_rdata", m0_rdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        m0_acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (m0_ack) m0_acks++;
        end
        rst = 1'b1;
        cyc = 0; strobes = 0;
        while (!m1_ack && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (m0_ack) m0_acks++;
            if (bus_mem_w && bus_addr == 32'h0000_0050 && bus_wdata == 32'h0000_0077) strobes++;
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("abort_m1_latency", cyc, 32'd3);
        check("abort_m1_owner", 32'(owner), 32'd1);
        check("abort_m1_strobes", strobes, 32'd1);
        check("abort_no_m0_ack", m0_acks, 32'd0);
        @(negedge clk);

        // LAT sweep on the LAT=0 and LAT=15 instances with one write each.
        check("sweep_idle0", 32'(z0_busy), 32'd0);
        check("sweep_idle15", 32'(z15_busy), 32'd0);
        @(negedge clk);
        m0_we = 1'b1; m0_addr = 32'h0000_0008; m0_wdata = 32'h0000_0099;
        z0_req = 1'b1; z15_req = 1'b1;
        cyc = 0; lat0 = -1; lat15 = -1; st0 = 0; st15 = 0;
        while ((lat0 < 0 || lat15 < 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (z0_bus_mem_w) st0++;
            if (z15_bus_mem_w) st15++;
            if (z0_m0_ack && lat0 < 0) begin lat0 = cyc; z0_req = 1'b0; end
            if (z15_m0_ack && lat15 < 0) begin lat15 = cyc; z15_req = 1'b0; end
        end
        z0_req = 1'b0; z15_req = 1'b0;
        check("lat0_latency", lat0, 32'd2);
        check("lat15_latency", lat15, 32'd17);
        check("lat0_strobes", st0, 32'd1);
        check("lat15_strobes", st15, 32'd1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mio_bus_arbiter.md
# mio_bus_arbiter

Two-master arbiter and sequencer for the shared memory/IO bus. It places one transaction at a time onto the single bus port (address, mem_w, write data, read data) that feeds the address decoder in front of data RAM, GPIO and counter. Master 0 is the multicycle CPU and master 1 is the debug/DMA loader. Grants alternate round-robin, each access is held for a fixed latency, and completion is signalled with a one-cycle ack.

## Interface
- LAT, 1, extra bus-hold cycles after the address cycle, covering synchronous RAM read latency; legal range 0..15

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req  in  1  master 0 requests a transaction
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_rdata  out  32  master 0 read data, valid while m0_ack=1, held until the next master-0 read completes
- m0_ack  out  1  one-cycle completion pulse to master 0
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same widths and meaning for master 1
- bus_addr  out  32  address to decoder
- bus_mem_w  out  1  write strobe to decoder
- bus_wdata  out  32  write data to decoder
- bus_rdata  in  32  read data from decoder (combinational mux of RAM/peripherals)
- owner  out  1  index of the current or most recent grantee
- busy  out  1  high in ACCESS and DONE

## Operation
- FSM states: IDLE, ACCESS, DONE. A 4-bit counter cnt is used in ACCESS.
- IDLE
  - bus_addr, bus_wdata and bus_mem_w are driven to 0.
  - If any req is high, select the grantee, latch its we/addr/wdata, set owner, load cnt=LAT and go to ACCESS.
  - If no req is high, stay in IDLE.
- Selection
  - A single requester wins.
  - If both request, the master not granted last wins. The last-granted flag resets to 1, so m0 wins the first tie.
- ACCESS
  - bus_addr and bus_wdata are driven from latched values for all LAT+1 cycles.
  - bus_mem_w = latched we only in the first ACCESS cycle. A peripheral with write side effects sees exactly one strobe.
  - If cnt≠0, decrement cnt.
  - If cnt=0 and the access is a read, capture bus_rdata into the grantee's rdata register; then go to DONE.
  - Writes do not update rdata.
- DONE
  - Pulse the grantee's ack for one cycle.
  - The bus returns to 0.
  - Record the grantee as last-granted and go to IDLE.
- Requester rule: hold req, we, addr and wdata stable until ack, then drop req in the cycle after ack.
  - Inputs are latched at grant, so changes after grant have no effect on the current transaction.
  - req still high in the IDLE cycle after ack is treated as a new request.
- The non-granted master's req is ignored until the next IDLE. Its ack stays 0.
- Fairness: with both masters requesting continuously, grants strictly alternate, so a master waits at most one foreign transaction.
- Reset value of every output (asserted immediately when rst falls): bus_addr=0, bus_wdata=0, bus_mem_w=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, owner=0, busy=0.
  - FSM goes to IDLE, cnt=0, last-granted=1.
  - Reset during ACCESS aborts the transaction with no ack; a write already strobed is not undone.

## Timing
- req sampled high at edge E0 (IDLE): ACCESS occupies cycles E0..E0+LAT, DONE/ack is the cycle after E0+LAT+1.
- Request-to-ack latency = LAT+2 cycles. Back-to-back throughput = 1 transaction per LAT+3 cycles.
- Read data is registered from bus_rdata at the last ACCESS edge and is stable in the ack cycle and beyond.
- There is no combinational path from any req to any bus output; all bus outputs are registered.

## Test plan
- Reset: hold rst=0, drive both req=1 → all outputs 0, no ack. Release rst → m0 is granted first (owner=0).
- Single read, LAT=1: m0 reads addr 0x00000010, bus_rdata=0xDEADBEEF → bus_addr=0x10 for 2 cycles, bus_mem_w=0 throughout, m0_ack pulses 3 cycles after req, m0_rdata=0xDEADBEEF.
- Single write: m1 writes 0x12345678 to 0xF0000004 → bus_mem_w high for exactly 1 cycle with that addr/data, m1_ack one cycle, m1_rdata unchanged.
- Contention: both masters request continuously for 4 transactions → grant order m0, m1, m0, m1, one ack per transaction, never both acks high.
- Abort: pull rst low in the second ACCESS cycle of an m0 read → bus outputs 0 immediately, no m0_ack. After release, a pending m1 request is granted normally.
- LAT sweep 0 and 15: req-to-ack = 2 and 17 cycles respectively, and bus_mem_w strobes once per write.
